// File: rtl/sched_pkg.sv
// Shared types and sizing for the tick scheduler: channel count, index and
// divider widths, and the per-channel configuration record.
package sched_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int DIV_W  = 8;
  localparam int BASE_W = 32;

  typedef logic [CH_W-1:0]   ch_idx_t;
  typedef logic [NUM_CH-1:0] ch_vec_t;
  typedef logic [DIV_W-1:0]  div_t;

  typedef struct packed {
    div_t div;
    logic en;
  } ch_cfg_t;

  // Channel indices wrap naturally because NUM_CH is a power of two.
  function automatic ch_idx_t ch_next(input ch_idx_t ch);
    return ch + ch_idx_t'(1);
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Timed-event handshake between the scheduler (master) and its consumer (slave).
interface tick_scheduler_if;
  import sched_pkg::*;

  logic    event_valid;
  ch_idx_t event_ch;
  logic    event_ready;

  modport master (output event_valid, output event_ch, input event_ready);
  modport slave  (input event_valid, input event_ch, output event_ready);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr.
module rr_arbiter
  import sched_pkg::*;
(
  input  ch_vec_t req,
  input  ch_idx_t ptr,
  output ch_idx_t grant,
  output logic    any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant = ptr;
    any   = 1'b0;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[ptr + ch_idx_t'(i)]) begin
        grant = ptr + ch_idx_t'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Base-rate tick generator, per-channel dividers and a round-robin event port
// that serialises channel fires into one valid/ready stream.
module tick_scheduler
  import sched_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic [BASE_W-1:0]   base_period,
  input  logic                cfg_we,
  input  ch_idx_t             cfg_ch,
  input  div_t                cfg_div,
  input  logic                cfg_en,
  input  logic                ovr_clr,
  output logic                base_tick,
  tick_scheduler_if.master    evt,
  output ch_vec_t             pending,
  output ch_vec_t             overrun
);

  logic [BASE_W-1:0] base_cnt_q, base_cnt_d, period_m1;
  logic              base_tick_q, base_tick_d;
  div_t              cnt_q [NUM_CH];
  div_t              cnt_d [NUM_CH];
  ch_cfg_t           cfg_q [NUM_CH];
  ch_cfg_t           cfg_d [NUM_CH];
  ch_vec_t           fire;
  ch_vec_t           pending_q, pending_d, overrun_q, overrun_d;
  logic              valid_q, valid_d;
  ch_idx_t           ch_q, ch_d, rr_ptr_q, rr_ptr_d, ptr_sel, grant;
  logic              accept, load, any;
  ch_vec_t           acc_mask, pres_mask, clr_mask, req;

  // The >= compare catches up immediately when the period shrinks below the count.
  always_comb begin
    period_m1   = (base_period == '0) ? '0 : base_period - BASE_W'(1);
    base_tick_d = (base_cnt_q >= period_m1);
    base_cnt_d  = base_tick_d ? '0 : base_cnt_q + BASE_W'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    cfg_d = cfg_q;
    fire  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && cfg_ch == ch_idx_t'(i)) begin
        cfg_d[i] = '{div: cfg_div, en: cfg_en};
        cnt_d[i] = cfg_div;
      end else if (base_tick_q && cfg_q[i].en) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = cfg_q[i].div;
          fire[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - div_t'(1);
        end
      end
    end
  end

  // A presented event is never retracted, so config clears skip that channel.
  always_comb begin
    accept    = valid_q && evt.event_ready;
    acc_mask  = accept  ? (ch_vec_t'(1) << ch_q) : '0;
    pres_mask = valid_q ? (ch_vec_t'(1) << ch_q) : '0;
    clr_mask  = (cfg_we ? (ch_vec_t'(1) << cfg_ch) : '0) & ~pres_mask;
    pending_d = ((pending_q & ~acc_mask) | fire) & ~clr_mask;
    overrun_d = ((overrun_q & ~{NUM_CH{ovr_clr}}) | (fire & pending_q & ~acc_mask)) & ~clr_mask;
    req       = pending_q & ~pres_mask & ~clr_mask;
    ptr_sel   = accept ? ch_next(ch_q) : rr_ptr_q;
  end

  rr_arbiter u_arb (
    .req   (req),
    .ptr   (ptr_sel),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    load     = !valid_q || accept;
    valid_d  = valid_q;
    ch_d     = ch_q;
    rr_ptr_d = accept ? ch_next(ch_q) : rr_ptr_q;
    if (load) begin
      valid_d = any;
      if (any) ch_d = grant;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      base_cnt_q  <= '0;
      base_tick_q <= 1'b0;
      // NOTE: the per-channel arrays are tiny register files, so they are reset like any other flop.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        cfg_q[i] <= '0;
      end
      pending_q <= '0;
      overrun_q <= '0;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      rr_ptr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      base_cnt_q  <= base_cnt_d;
      base_tick_q <= base_tick_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      valid_q     <= valid_d;
      ch_q        <= ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign base_tick       = base_tick_q;
  assign pending         = pending_q;
  assign overrun         = overrun_q;
  assign evt.event_valid = valid_q;
  assign evt.event_ch    = ch_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a behavioural model of the scheduler.
module tb_tick_scheduler;
  import sched_pkg::*;

  logic        clock  = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] base_period = 32'd5;
  logic        cfg_we = 1'b0;
  ch_idx_t     cfg_ch = '0;
  div_t        cfg_div = '0;
  logic        cfg_en = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        base_tick;
  ch_vec_t     pending, overrun;

  tick_scheduler_if evt_if ();

  tick_scheduler dut (
    .clock       (clock),
    .resetn      (resetn),
    .base_period (base_period),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_en      (cfg_en),
    .ovr_clr     (ovr_clr),
    .base_tick   (base_tick),
    .evt         (evt_if.master),
    .pending     (pending),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: channel firing is derived from how many enabled base ticks a
  // channel has seen since its last configuration.
  int m_elapsed;
  bit m_tick;
  int m_div   [NUM_CH];
  bit m_en    [NUM_CH];
  int m_ticks [NUM_CH];
  bit m_pend  [NUM_CH];
  bit m_ovr   [NUM_CH];
  bit m_valid;
  int m_ch, m_ptr;
  int acc_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0; m_tick = 0; m_valid = 0; m_ch = 0; m_ptr = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c] = 0; m_en[c] = 0; m_ticks[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
    end
  endtask

  task automatic model_step();
    int  eff, start, n_ch;
    bit  accept, n_valid, acc_c;
    bit  fire [NUM_CH];
    bit  clr  [NUM_CH];
    eff    = (base_period == 0) ? 1 : int'(base_period);
    accept = m_valid && evt_if.event_ready;
    if (accept) acc_log.push_back(m_ch);
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit;
      hit     = cfg_we && (int'(cfg_ch) == c);
      clr[c]  = hit && !(m_valid && m_ch == c);
      fire[c] = 0;
      if (!hit && m_tick && m_en[c]) begin
        m_ticks[c]++;
        fire[c] = (m_ticks[c] % (m_div[c] + 1)) == 0;
      end
    end
    n_valid = m_valid;
    n_ch    = m_ch;
    if (!m_valid || accept) begin
      start   = accept ? (m_ch + 1) % NUM_CH : m_ptr;
      n_valid = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (start + k) % NUM_CH;
        if (!n_valid && m_pend[c] && !(m_valid && c == m_ch) && !clr[c]) begin
          n_valid = 1;
          n_ch    = c;
        end
      end
    end
    if (accept) m_ptr = (m_ch + 1) % NUM_CH;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_c = accept && (m_ch == c);
      if (ovr_clr) m_ovr[c] = 0;
      if (fire[c] && m_pend[c] && !acc_c) m_ovr[c] = 1;
      if (clr[c]) m_ovr[c] = 0;
      if (acc_c) m_pend[c] = 0;
      if (fire[c]) m_pend[c] = 1;
      if (clr[c]) m_pend[c] = 0;
    end
    if (cfg_we) begin
      m_div[cfg_ch]   = int'(cfg_div);
      m_en[cfg_ch]    = cfg_en;
      m_ticks[cfg_ch] = 0;
    end
    m_elapsed++;
    m_tick = (m_elapsed >= eff);
    if (m_tick) m_elapsed = 0;
    m_valid = n_valid;
    m_ch    = n_ch;
  endtask

  task automatic compare();
    ch_vec_t ep, eo;
    for (int c = 0; c < NUM_CH; c++) begin
      ep[c] = m_pend[c];
      eo[c] = m_ovr[c];
    end
    check("base_tick", base_tick, m_tick);
    check("event_valid", evt_if.event_valid, m_valid);
    if (m_valid) check("event_ch", evt_if.event_ch, m_ch);
    check("pending", pending, ep);
    check("overrun", overrun, eo);
  endtask

  task automatic cycle();
    @(posedge clock);
    if (resetn) model_step();
    cyc++;
    #1;
    compare();
  endtask

  task automatic do_reset();
    cfg_we = 0; ovr_clr = 0; evt_if.event_ready = 0;
    #2 resetn = 0;
    #1;
    check("rst_base_tick", base_tick, 0);
    check("rst_event_valid", evt_if.event_valid, 0);
    check("rst_event_ch", evt_if.event_ch, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    model_reset();
    @(posedge clock);
    #1 resetn = 1;
    cyc = 0;
    acc_log.delete();
  endtask

  task automatic write_cfg(input int ch, input int div, input bit en);
    cfg_we = 1; cfg_ch = ch_idx_t'(ch); cfg_div = div_t'(div); cfg_en = en;
    cycle();
    cfg_we = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, ticks;
    bit seen;
    evt_if.event_ready = 0;

    // Base tick alone, period 5 then period 0.
    base_period = 5;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle();
      check("bt_p5", base_tick, (cyc % 5) == 0);
    end
    base_period = 0;
    repeat (8) begin
      cycle();
      check("bt_p0", base_tick, 1);
    end

    // Single channel: ch1 every 4th base tick of period 2.
    do_reset();
    base_period = 2;
    evt_if.event_ready = 1;
    write_cfg(1, 3, 1);
    repeat (60) cycle();
    bad = 0;
    foreach (acc_log[i]) if (acc_log[i] != 1) bad++;
    check("single_only_ch1", bad, 0);
    check("single_count", acc_log.size(), 7);

    // Simultaneous fire on all channels: strict rotation, no overrun.
    do_reset();
    base_period = 8;
    evt_if.event_ready = 1;
    for (int c = 0; c < NUM_CH; c++) write_cfg(c, 0, 1);
    repeat (60) cycle();
    check("simul_count", acc_log.size(), 28);
    if (acc_log.size() > 0) check("simul_first", acc_log[0], 0);
    for (int i = 1; i < acc_log.size(); i++)
      check("simul_rr_order", acc_log[i], (acc_log[i-1] + 1) % NUM_CH);
    check("simul_overrun", overrun, 0);

    // Back-pressure on ch2, overrun, clear, then a single delivery.
    do_reset();
    base_period = 2;
    write_cfg(2, 0, 1);
    repeat (8) cycle();
    check("bp_valid", evt_if.event_valid, 1);
    check("bp_ch", evt_if.event_ch, 2);
    check("bp_overrun2", overrun[2], 1);
    base_period = 1000;
    ovr_clr = 1;
    cycle();
    ovr_clr = 0;
    check("bp_ovr_clr", overrun, 0);
    evt_if.event_ready = 1;
    acc_log.delete();
    repeat (10) cycle();
    check("bp_one_event", acc_log.size(), 1);
    check("bp_pending_idle", pending, 0);

    // Config write on a pending-but-not-presented channel.
    do_reset();
    base_period = 2;
    write_cfg(0, 0, 1);
    write_cfg(3, 0, 1);
    repeat (4) cycle();
    check("cfg_pend3_before", pending[3], 1);
    check("cfg_presented_ch0", evt_if.event_ch, 0);
    write_cfg(3, 1, 0);
    check("cfg_pend3_cleared", pending[3], 0);
    evt_if.event_ready = 1;
    acc_log.delete();
    repeat (20) cycle();
    bad = 0;
    foreach (acc_log[i]) if (acc_log[i] == 3) bad++;
    check("cfg_no_ch3_event", bad, 0);
    write_cfg(3, 1, 1);
    ticks = base_tick ? 1 : 0;
    seen  = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cycle();
      if (pending[3]) seen = 1;
      else if (base_tick) ticks++;
    end
    check("cfg_refire_seen", seen, 1);
    check("cfg_refire_ticks", ticks, 2);

    // Random traffic against the model.
    do_reset();
    base_period = 3;
    repeat (3000) begin
      evt_if.event_ready = ($urandom_range(0, 3) != 0);
      cfg_we  = ($urandom_range(0, 19) == 0);
      cfg_ch  = ch_idx_t'($urandom_range(0, NUM_CH - 1));
      cfg_div = div_t'($urandom_range(0, 5));
      cfg_en  = ($urandom_range(0, 3) != 0);
      ovr_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) base_period = $urandom_range(0, 4);
      cycle();
    end

    // Mid-burst asynchronous reset, then base tick restarts cleanly.
    base_period = 4;
    do_reset();
    repeat (8) begin
      cycle();
      check("arst_bt", base_tick, (cyc % 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
